// File: rtl/frame_tx_datapath.sv
// rtl/frame_tx_datapath.sv - ROM address counter, CRC-32 and registered TXD/TXK mux for the optical transmit path
// Optional payload word counter on WORD_CNT is built when FRM_TX_WCOUNT_EN is defined.

module frame_tx_crc32_d16 (
  input  logic [31:0] crc_in,
  input  logic [15:0] data,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  // Reflected CRC-32, one bit per iteration, DIN[0] first so the low byte goes out first.
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 16; i++) begin
      c = (c >> 1) ^ (((c[0] ^ data[i]) == 1'b1) ? 32'hEDB88320 : 32'h0);
    end
    crc_next = c;
  end

endmodule

module frame_tx_datapath #(
  parameter logic [15:0] IDLE_WORD = 16'h50BC,
  parameter logic [1:0]  IDLE_K    = 2'b01,
  parameter logic [15:0] SOP_WORD  = 16'hF7FB,
  parameter logic [1:0]  SOP_K     = 2'b11,
  parameter logic [15:0] PRE_WORD  = 16'h5555,
  parameter logic [15:0] SOF_WORD  = 16'hD555,
  parameter logic [15:0] EOP_WORD  = 16'hFDF7,
  parameter logic [1:0]  EOP_K     = 2'b11
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INC_ROM,
  input  logic        RST_ROM,
  input  logic        CLR_CRC,
  input  logic        CRC_DV,
  input  logic [15:0] DIN,
  output logic [2:0]  ROM_ADDR,
  output logic [15:0] TXD,
  output logic [1:0]  TXK,
  output logic [31:0] CRC_OUT,
  output logic [11:0] WORD_CNT
);

  logic [2:0]  rom_addr;
  logic [31:0] crc_reg;
  logic [31:0] crc_next;
  logic [15:0] txd_nxt;
  logic [1:0]  txk_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rom_addr <= 3'd0;
    end else if (RST_ROM) begin
      rom_addr <= 3'd0;
    end else if (INC_ROM) begin
      rom_addr <= rom_addr + 3'd1;
    end
  end

  assign ROM_ADDR = rom_addr;

  frame_tx_crc32_d16 u_crc (
    .crc_in   (crc_reg),
    .data     (DIN),
    .crc_next (crc_next)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      crc_reg <= 32'hFFFFFFFF;
    end else if (CLR_CRC) begin
      crc_reg <= 32'hFFFFFFFF;
    end else if (CRC_DV) begin
      crc_reg <= crc_next;
    end
  end

  // Combinational so the first CRC word already includes the last payload word.
  assign CRC_OUT = ~crc_reg;

  always_comb begin
    txd_nxt = IDLE_WORD;
    txk_nxt = IDLE_K;
    case (rom_addr)
      3'd0: begin txd_nxt = IDLE_WORD; txk_nxt = IDLE_K; end
      3'd1: begin txd_nxt = SOP_WORD;  txk_nxt = SOP_K;  end
      3'd2: begin txd_nxt = PRE_WORD;  txk_nxt = 2'b00;  end
      3'd3: begin txd_nxt = SOF_WORD;  txk_nxt = 2'b00;  end
      3'd4: begin
        txd_nxt = CRC_DV ? DIN : CRC_OUT[15:0];
        txk_nxt = 2'b00;
      end
      3'd5: begin txd_nxt = CRC_OUT[31:16]; txk_nxt = 2'b00; end
      3'd6: begin txd_nxt = EOP_WORD;  txk_nxt = EOP_K;  end
      default: begin txd_nxt = IDLE_WORD; txk_nxt = IDLE_K; end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TXD <= IDLE_WORD;
      TXK <= IDLE_K;
    end else begin
      TXD <= txd_nxt;
      TXK <= txk_nxt;
    end
  end

`ifdef FRM_TX_WCOUNT_EN
  logic [11:0] word_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_cnt <= 12'd0;
    end else if (CLR_CRC) begin
      word_cnt <= 12'd0;
    end else if (CRC_DV && (word_cnt != 12'hFFF)) begin
      word_cnt <= word_cnt + 12'd1;
    end
  end

  assign WORD_CNT = word_cnt;
`else
  assign WORD_CNT = 12'd0;
`endif

endmodule

// File: tb/tb_frame_tx_datapath.sv
// tb/tb_frame_tx_datapath.sv - scoreboard bench for frame_tx_datapath against a bytewise CRC-32 frame model

module tb_frame_tx_datapath;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        INC_ROM = 1'b0;
  logic        RST_ROM = 1'b0;
  logic        CLR_CRC = 1'b0;
  logic        CRC_DV = 1'b0;
  logic [15:0] DIN = 16'h0;
  logic [2:0]  ROM_ADDR;
  logic [15:0] TXD;
  logic [1:0]  TXK;
  logic [31:0] CRC_OUT;
  logic [11:0] WORD_CNT;

  frame_tx_datapath dut (
    .CLK      (CLK),
    .RST      (RST),
    .INC_ROM  (INC_ROM),
    .RST_ROM  (RST_ROM),
    .CLR_CRC  (CLR_CRC),
    .CRC_DV   (CRC_DV),
    .DIN      (DIN),
    .ROM_ADDR (ROM_ADDR),
    .TXD      (TXD),
    .TXK      (TXK),
    .CRC_OUT  (CRC_OUT),
    .WORD_CNT (WORD_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] txd;
    logic [1:0]  txk;
    logic [2:0]  addr;
    logic [31:0] crc;
    logic [11:0] wcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: address as an integer, CRC recomputed from all payload bytes since the last clear.
  int          m_addr = 0;
  logic [7:0]  m_bytes[$];
  int          m_wcnt = 0;

  function automatic logic [31:0] crc_of_bytes();
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (m_bytes[i]) begin
      c = c ^ {24'h0, m_bytes[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("TXD", {16'h0, TXD}, {16'h0, e.txd});
      check("TXK", {30'h0, TXK}, {30'h0, e.txk});
      check("ROM_ADDR", {29'h0, ROM_ADDR}, {29'h0, e.addr});
      check("CRC_OUT", CRC_OUT, e.crc);
      check("WORD_CNT", {20'h0, WORD_CNT}, {20'h0, e.wcnt});
    end
  end

  // One clock: predict output from pre-edge model state, advance the model, queue the expectation.
  task automatic step(input logic inc, input logic rrom, input logic clr, input logic dv, input logic [15:0] din);
    exp_t e;
    logic [31:0] crc_now;
    INC_ROM = inc; RST_ROM = rrom; CLR_CRC = clr; CRC_DV = dv; DIN = din;
    crc_now = crc_of_bytes();
    case (m_addr)
      1: begin e.txd = 16'hF7FB; e.txk = 2'b11; end
      2: begin e.txd = 16'h5555; e.txk = 2'b00; end
      3: begin e.txd = 16'hD555; e.txk = 2'b00; end
      4: begin e.txd = dv ? din : crc_now[15:0]; e.txk = 2'b00; end
      5: begin e.txd = crc_now[31:16]; e.txk = 2'b00; end
      6: begin e.txd = 16'hFDF7; e.txk = 2'b11; end
      default: begin e.txd = 16'h50BC; e.txk = 2'b01; end
    endcase
    @(posedge CLK);
    if (rrom) m_addr = 0;
    else if (inc) m_addr = (m_addr + 1) % 8;
    if (clr) begin
      m_bytes.delete();
      m_wcnt = 0;
    end else if (dv) begin
      m_bytes.push_back(din[7:0]);
      m_bytes.push_back(din[15:8]);
      if (m_wcnt < 4095) m_wcnt++;
    end
    e.addr = m_addr[2:0];
    e.crc  = crc_of_bytes();
`ifdef FRM_TX_WCOUNT_EN
    e.wcnt = m_wcnt[11:0];
`else
    e.wcnt = 12'd0;
`endif
    exp_q.push_back(e);
    #1;
  endtask

  task automatic frame_head(input logic [15:0] words[$]);
    step(1, 0, 0, 0, 16'h0);
    step(1, 0, 1, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    foreach (words[i]) step(0, 0, 0, 1, words[i]);
  endtask

  task automatic run_frame(input logic [15:0] words[$]);
    frame_head(words);
    step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    RST = 1'b1;
    INC_ROM = 0; RST_ROM = 0; CLR_CRC = 0; CRC_DV = 0; DIN = 16'h0;
    m_addr = 0; m_bytes.delete(); m_wcnt = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst TXD", {16'h0, TXD}, 32'h50BC);
      check("rst TXK", {30'h0, TXK}, 32'h1);
      check("rst ROM_ADDR", {29'h0, ROM_ADDR}, 32'h0);
      check("rst CRC_OUT", CRC_OUT, 32'h0);
      check("rst WORD_CNT", {20'h0, WORD_CNT}, 32'h0);
      @(negedge CLK);
      #2;
    end
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [15:0] w[$];
    do_reset();
    repeat (2) step(0, 0, 0, 0, 16'h0);

    for (int k = 0; k < 8; k++) step(1, 0, 0, 0, 16'h0);
    repeat (5) step(1, 0, 0, 0, 16'h0);
    step(1, 1, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);

    w = '{16'h3231, 16'h3433, 16'h3635, 16'h3837};
    run_frame(w);
    check("known CRC", CRC_OUT, 32'h9AE0DAAF);

    step(0, 0, 1, 1, 16'hA5A5);
    check("clr over dv", CRC_OUT, 32'h0);

    w.delete();
    run_frame(w);

    for (int f = 0; f < 6; f++) begin
      w.delete();
      for (int i = 0; i < int'($urandom_range(1, 7)); i++) w.push_back(16'($urandom));
      run_frame(w);
    end

    w = '{16'h1234, 16'hBEEF, 16'h0F0F};
    frame_head(w);
    do_reset();
    step(0, 0, 0, 0, 16'h0);
    w = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    run_frame(w);
`ifdef FRM_TX_WCOUNT_EN
    check("word count", {20'h0, WORD_CNT}, 32'd4);
`else
    check("word count", {20'h0, WORD_CNT}, 32'd0);
`endif

    repeat (2) step(0, 0, 0, 0, 16'h0);
    @(negedge CLK);
    #2;
    check("queue drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
